// File: rtl/local_eject_buffer.sv
// Ejection buffer behind the local-port crossbar mux.
// Holds ejected packets in a show-ahead FIFO and hands them to the compute unit
// over valid/ready. Raises an early stall to the mux, which cannot be backpressured.
// Unpacks the head packet fields and counts delivered packets per type.
module local_eject_buffer #(
  parameter int unsigned DataWidth       = 256,
  parameter int unsigned PayloadLen      = 128,
  parameter int unsigned ReductionBitPos = 254,
  parameter int unsigned IndexPos        = 128,
  parameter int unsigned IndexWidth      = 16,
  parameter int unsigned WeightPos       = 144,
  parameter int unsigned WeightWidth     = 8,
  parameter int unsigned EjectFIFODepth  = 8,
  parameter int unsigned StallThreshold  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DataWidth-1:0]   in_data,
  input  logic                   in_send,
  output logic                   out_pipeline_stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DataWidth-1:0]   out_data,
  output logic [PayloadLen-1:0]  out_payload,
  output logic [IndexWidth-1:0]  out_index,
  output logic [WeightWidth-1:0] out_weight,
  output logic                   out_is_reduction,
  output logic [15:0]            reduction_cnt,
  output logic [15:0]            normal_cnt,
  output logic                   overflow_err
);

  localparam int unsigned PtrW       = $clog2(EjectFIFODepth);
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned StallLevel = EjectFIFODepth - StallThreshold;

  logic [DataWidth-1:0] mem [EjectFIFODepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      count_next;
  logic                 valid_q;
  logic                 stall_q;
  logic                 ovf_q;
  logic [15:0]          red_cnt_q;
  logic [15:0]          norm_cnt_q;
  logic                 wr_req;
  logic                 rd_c;
  logic                 full;
  logic                 wr_acc;
  logic [DataWidth-1:0] head;

  // Handshake decode and next occupancy; a full buffer still accepts when the head leaves.
  always_comb begin
    wr_req     = in_send && in_data[DataWidth-1];
    rd_c       = valid_q && out_ready;
    full       = (count == CntW'(EjectFIFODepth));
    wr_acc     = wr_req && (!full || rd_c);
    count_next = count + CntW'(wr_acc) - CntW'(rd_c);
  end

  // Pointers, occupancy, stall, sticky overflow and saturating delivery counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      valid_q    <= 1'b0;
      stall_q    <= 1'b0;
      ovf_q      <= 1'b0;
      red_cnt_q  <= '0;
      norm_cnt_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PtrW'(1);
      if (rd_c)   rd_ptr <= rd_ptr + PtrW'(1);
      count   <= count_next;
      valid_q <= (count_next != '0);
      stall_q <= (count_next >= CntW'(StallLevel));
      if (wr_req && !wr_acc) ovf_q <= 1'b1;
      if (rd_c) begin
        if (head[ReductionBitPos]) begin
          if (red_cnt_q != 16'hFFFF) red_cnt_q <= red_cnt_q + 16'd1;
        end else begin
          if (norm_cnt_q != 16'hFFFF) norm_cnt_q <= norm_cnt_q + 16'd1;
        end
      end
    end
  end

  // Packet storage; contents are not reset and a write during reset is discarded.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= in_data;
  end

  // Head entry and its field slices.
  always_comb begin
    head             = mem[rd_ptr];
    out_data         = head;
    out_payload      = head[PayloadLen-1:0];
    out_index        = head[IndexPos +: IndexWidth];
    out_weight       = head[WeightPos +: WeightWidth];
    out_is_reduction = head[ReductionBitPos];
  end

  assign out_valid          = valid_q;
  assign out_pipeline_stall = stall_q;
  assign overflow_err       = ovf_q;
  assign reduction_cnt      = red_cnt_q;
  assign normal_cnt         = norm_cnt_q;

endmodule

// File: tb/tb_local_eject_buffer.sv
// Directed bench for local_eject_buffer: fill/stall, overflow, full pass-through,
// field unpacking, counter saturation and mid-operation reset.
module tb_local_eject_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic         in_send;
  logic         out_pipeline_stall;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic [127:0] out_payload;
  logic [15:0]  out_index;
  logic [7:0]   out_weight;
  logic         out_is_reduction;
  logic [15:0]  reduction_cnt;
  logic [15:0]  normal_cnt;
  logic         overflow_err;

  int n_cmp = 0;
  int n_err = 0;

  local_eject_buffer dut (
    .clk                (clk),
    .rst                (rst),
    .in_data            (in_data),
    .in_send            (in_send),
    .out_pipeline_stall (out_pipeline_stall),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_payload        (out_payload),
    .out_index          (out_index),
    .out_weight         (out_weight),
    .out_is_reduction   (out_is_reduction),
    .reduction_cnt      (reduction_cnt),
    .normal_cnt         (normal_cnt),
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
    $fatal(1);
  end

  function automatic logic [255:0] mk(input logic v, input logic r, input logic [15:0] idx,
                                      input logic [7:0] w, input logic [127:0] pl);
    logic [255:0] p;
    p = '0;
    p[255] = v;
    p[254] = r;
    p[143:128] = idx;
    p[151:144] = w;
    p[127:0] = pl;
    return p;
  endfunction

  // One active edge, then settle on the falling edge for sampling and driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_send = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_pipeline_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", out_pipeline_stall); end
    n_cmp++; if (reduction_cnt !== 16'd0) begin n_err++; $display("FAIL reset_red_cnt got %h want 0", reduction_cnt); end
    n_cmp++; if (normal_cnt !== 16'd0) begin n_err++; $display("FAIL reset_norm_cnt got %h want 0", normal_cnt); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'h1234); in_send = 1'b1; out_ready = 1'b1;
    step();
    in_send = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_cmp++; if (out_payload !== 128'h1234) begin n_err++; $display("FAIL single_payload got %h want 1234", out_payload); end
    n_cmp++; if (out_is_reduction !== 1'b0) begin n_err++; $display("FAIL single_is_red got %b want 0", out_is_reduction); end
    n_cmp++; if (normal_cnt !== 16'd0) begin n_err++; $display("FAIL single_norm_pre got %h want 0", normal_cnt); end
    step();
    n_cmp++; if (normal_cnt !== 16'd1) begin n_err++; $display("FAIL single_norm_cnt got %h want 1", normal_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'h100 + 128'(i)); in_send = 1'b1;
      step();
      if (i == 3) begin
        n_cmp++; if (out_pipeline_stall !== 1'b0) begin n_err++; $display("FAIL fill_stall_at4 got %b want 0", out_pipeline_stall); end
      end
      if (i == 4) begin
        n_cmp++; if (out_pipeline_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall_at5 got %b want 1", out_pipeline_stall); end
      end
    end
    in_send = 1'b0;
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL fill_ovf got %b want 0", overflow_err); end
    n_cmp++; if (out_payload !== 128'h100) begin n_err++; $display("FAIL fill_head got %h want 100", out_payload); end
    n_cmp++; if (out_pipeline_stall !== 1'b1) begin n_err++; $display("FAIL fill_stall_full got %b want 1", out_pipeline_stall); end
  endtask

  task automatic test_overflow();
    in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'hDEAD); in_send = 1'b1; out_ready = 1'b0;
    step();
    in_send = 1'b0;
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", overflow_err); end
    n_cmp++; if (out_payload !== 128'h100) begin n_err++; $display("FAIL ovf_head got %h want 100", out_payload); end
    step();
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
  endtask

  task automatic test_full_simul();
    in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'h200); in_send = 1'b1; out_ready = 1'b1;
    step();
    in_send = 1'b0; out_ready = 1'b0;
    n_cmp++; if (normal_cnt !== 16'd2) begin n_err++; $display("FAIL simul_norm got %h want 2", normal_cnt); end
    n_cmp++; if (out_payload !== 128'h101) begin n_err++; $display("FAIL simul_head got %h want 101", out_payload); end
    n_cmp++; if (out_pipeline_stall !== 1'b1) begin n_err++; $display("FAIL simul_stall got %b want 1", out_pipeline_stall); end
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL simul_ovf got %b want 1", overflow_err); end
  endtask

  task automatic test_drain();
    logic [127:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 128'h101 + 128'(i) : 128'h200;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (out_payload !== exp) begin n_err++; $display("FAIL drain_order[%0d] got %h want %h", i, out_payload, exp); end
      step();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", out_valid); end
    n_cmp++; if (normal_cnt !== 16'd10) begin n_err++; $display("FAIL drain_norm got %h want 000a", normal_cnt); end
    n_cmp++; if (out_pipeline_stall !== 1'b0) begin n_err++; $display("FAIL drain_stall got %b want 0", out_pipeline_stall); end
  endtask

  task automatic test_reduction();
    in_data = mk(1'b1, 1'b1, 16'h00A5, 8'd6, 128'hABC); in_send = 1'b1; out_ready = 1'b0;
    step();
    n_cmp++; if (out_is_reduction !== 1'b1) begin n_err++; $display("FAIL red_flag got %b want 1", out_is_reduction); end
    n_cmp++; if (out_index !== 16'h00A5) begin n_err++; $display("FAIL red_index got %h want 00a5", out_index); end
    n_cmp++; if (out_weight !== 8'd6) begin n_err++; $display("FAIL red_weight got %0d want 6", out_weight); end
    n_cmp++; if (out_payload !== 128'hABC) begin n_err++; $display("FAIL red_payload got %h want abc", out_payload); end
    in_data = mk(1'b0, 1'b0, 16'h0, 8'h0, 128'h777); in_send = 1'b1; out_ready = 1'b1;
    step();
    in_send = 1'b0; out_ready = 1'b0;
    n_cmp++; if (reduction_cnt !== 16'd1) begin n_err++; $display("FAIL red_cnt got %h want 1", reduction_cnt); end
    n_cmp++; if (normal_cnt !== 16'd10) begin n_err++; $display("FAIL red_norm got %h want 000a", normal_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL invalid_write got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL invalid_write_late got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp;
    force dut.red_cnt_q = 16'hFFFE;
    #1;
    release dut.red_cnt_q;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = mk(1'b1, 1'b1, 16'(i), 8'h0, 128'h300 + 128'(i)); in_send = 1'b1;
      step();
      exp = (i == 0) ? 16'hFFFE : 16'hFFFF;
      n_cmp++; if (reduction_cnt !== exp) begin n_err++; $display("FAIL sat_cnt[%0d] got %h want %h", i, reduction_cnt, exp); end
    end
    in_send = 1'b0;
    step();
    out_ready = 1'b0;
    n_cmp++; if (reduction_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold got %h want ffff", reduction_cnt); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sat_empty got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'h400 + 128'(i)); in_send = 1'b1;
      step();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_queued got %b want 1", out_valid); end
    in_data = mk(1'b1, 1'b0, 16'h0, 8'h0, 128'h4FF); in_send = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; in_send = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", out_valid); end
    n_cmp++; if (out_pipeline_stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got %b want 0", out_pipeline_stall); end
    n_cmp++; if (reduction_cnt !== 16'd0) begin n_err++; $display("FAIL mid_red_cnt got %h want 0", reduction_cnt); end
    n_cmp++; if (normal_cnt !== 16'd0) begin n_err++; $display("FAIL mid_norm_cnt got %h want 0", normal_cnt); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL mid_ovf got %b want 0", overflow_err); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_write_ignored got %b want 0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_send = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_full_simul();
    test_drain();
    test_reduction();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
